// File: rtl/store_retire_buffer.sv
// ---------------------------------------------------------------------------
// store_retire_buffer
//
// Post-commit store buffer. Committed stores arrive from the store queue's
// retire port and are held in a circular FIFO. They drain one at a time to the
// memory bus, and the bus is yielded to the load path whenever possible.
// Buffered store data is forwarded to probing loads so that a load never
// observes memory that is stale relative to a store still waiting here.
//
// Ports
//   clock, reset        system clock; asynchronous active-high reset
//   sq_store_valid      SQ presents a committed store this cycle
//   sq_store_data/addr  store payload from the SQ
//   sb_full / sb_empty  occupancy flags (from the registered count)
//   sb_count            number of occupied entries
//   ld_mem_req          load path wants the memory bus this cycle
//   ld_fwd_addr         load address probing the buffer for forwarding
//   fwd_hit / fwd_data  youngest matching buffered store (combinational)
//   proc2mem_command    0=NONE, 2=STORE (LOAD is never driven here)
//   proc2mem_addr/data  head entry, address aligned to an 8-byte word
//   mem2proc_response   nonzero = memory accepted the request this cycle
// ---------------------------------------------------------------------------
module store_retire_buffer #(
  parameter int SB_DEPTH = 8,
  parameter int ADDR_W   = 64,
  parameter int DATA_W   = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        sq_store_valid,
  input  logic [DATA_W-1:0]           sq_store_data,
  input  logic [ADDR_W-1:0]           sq_store_addr,
  output logic                        sb_full,
  output logic                        sb_empty,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  input  logic                        ld_mem_req,
  input  logic [ADDR_W-1:0]           ld_fwd_addr,
  output logic                        fwd_hit,
  output logic [DATA_W-1:0]           fwd_data,
  output logic [1:0]                  proc2mem_command,
  output logic [ADDR_W-1:0]           proc2mem_addr,
  output logic [DATA_W-1:0]           proc2mem_data,
  input  logic [3:0]                  mem2proc_response
);

  localparam int IDX_W = $clog2(SB_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int CNT_W = IDX_W + 1;
  localparam int WRD_W = ADDR_W - 3;

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

  // Control state (reset)
  state_t             r_state;
  state_t             w_state_nxt;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;

  // Entry storage (not reset; validity is defined by head/count)
  logic [WRD_W-1:0]   r_addr [SB_DEPTH];
  logic [DATA_W-1:0]  r_data [SB_DEPTH];

  logic               w_enq;
  logic               w_deq;
  logic [IDX_W-1:0]   w_head_idx;
  logic [IDX_W-1:0]   w_tail_idx;
  logic [IDX_W-1:0]   w_fwd_idx;
  logic               w_unused_lsbs;

  // Only word addresses are tracked; byte offsets play no part in matching.
  assign w_unused_lsbs = ^{sq_store_addr[2:0], ld_fwd_addr[2:0]};

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];

  assign sb_full  = (r_count == CNT_W'(SB_DEPTH));
  assign sb_empty = (r_count == '0);
  assign sb_count = r_count;

  // Full comes from the registered count, so a same-cycle dequeue never
  // frees a slot for the incoming store; a store offered while full is dropped.
  assign w_enq = sq_store_valid && !sb_full;
  assign w_deq = (r_state == S_ISSUE) && (mem2proc_response != 4'd0);

  // Pointers and count. The pointers carry a wrap bit above the index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_tail <= r_tail + PTR_W'(1);
      if (w_deq) r_head <= r_head + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
    end
  end

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_addr[w_tail_idx] <= sq_store_addr[ADDR_W-1:3];
      r_data[w_tail_idx] <= sq_store_data;
    end
  end

  // Forwarding: scan oldest to youngest so the last match (youngest) wins.
  // The head stays visible while it is being issued.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = '0;
    w_fwd_idx = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      w_fwd_idx = w_head_idx + IDX_W'(i);
      if ((CNT_W'(i) < r_count) &&
          (r_addr[w_fwd_idx] == ld_fwd_addr[ADDR_W-1:3])) begin
        fwd_hit  = 1'b1;
        fwd_data = r_data[w_fwd_idx];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state. Loads own the bus unless the buffer is full; once a store
  // is on the bus it stays there until memory accepts it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if ((r_count != '0) && (!ld_mem_req || sb_full))
          w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_deq) begin
          if ((r_count != CNT_W'(1)) && !ld_mem_req) w_state_nxt = S_ISSUE;
          else                                       w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: driven from the state register and head pointer only.
  always_comb begin
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (r_state == S_ISSUE) begin
      proc2mem_command = CMD_STORE;
      proc2mem_addr    = {r_addr[w_head_idx], 3'b000};
      proc2mem_data    = r_data[w_head_idx];
    end
  end

endmodule
